// File: rtl/uart_mem_master_pkg.sv
// Command/reply byte codes, FSM state type and a byte-lane insert helper
// shared by the UART-driven memory bus master.
package uart_mem_master_pkg;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;
  localparam logic [7:0] RSP_BAD   = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_MEM,
    ST_RESP
  } state_t;

  // Fields arrive LSB first, so byte n of a field lands in lane n.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_mem_resp_shift.sv
// Response byte shifter: loaded with 1 or 4 bytes, presents them LSB first
// on a valid/ready handshake with one idle cycle between bytes.
module uart_mem_resp_shift (
  input  logic        sys_clk,
  input  logic        sys_resetn,
  input  logic        i_load,
  input  logic [31:0] i_load_data,
  input  logic [2:0]  i_load_cnt,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_last
);

  logic [31:0] r_shift;
  logic [2:0]  r_cnt;
  logic        r_valid;

  assign o_tx_data  = r_shift[7:0];
  assign o_tx_valid = r_valid;
  assign o_last     = (r_cnt == 3'd1);

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_shift <= 32'h0;
      r_cnt   <= 3'd0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_load_data;
      r_cnt   <= i_load_cnt;
      r_valid <= 1'b1;
    end else if (r_valid && i_tx_ready) begin
      r_shift <= {8'h00, r_shift[31:8]};
      r_cnt   <= r_cnt - 3'd1;
      r_valid <= 1'b0;
    end else if (!r_valid && (r_cnt != 3'd0)) begin
      // Re-arm on the cycle after a handshake: at most one byte per 2 cycles.
      r_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_mem_master.sv
// Serial-command bus initiator: turns 'R'/'W' byte frames from the UART into
// single-word transactions on the native mem_valid/mem_ready interface.
//   state   | meaning
//   IDLE    | waiting for a command byte
//   ADDR    | collecting 4 address bytes (LSB first)
//   DATA    | collecting 4 write-data bytes (writes only)
//   MEM     | mem_valid asserted, waiting for mem_ready or timeout
//   RESP    | sending reply byte(s) to the UART
module uart_mem_master
  import uart_mem_master_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_is_write;
  logic [1:0]    r_cnt;
  logic [TW-1:0] r_tmo;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic          r_mem_valid;
  logic          r_busy;

  logic          w_load;
  logic [31:0]   w_load_data;
  logic [2:0]    w_load_cnt;
  logic          w_tx_valid;
  logic          w_tx_last;
  logic [7:0]    w_tx_data;
  logic          w_field_done;

  assign w_field_done = rx_valid && (r_cnt == 2'd3);

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) r_state <= ST_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_data = 32'h0;
    w_load_cnt  = 3'd0;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          if ((rx_data == CMD_READ) || (rx_data == CMD_WRITE)) begin
            w_next = ST_ADDR;
          end else begin
            w_next      = ST_RESP;
            w_load      = 1'b1;
            w_load_data = {24'h0, RSP_BAD};
            w_load_cnt  = 3'd1;
          end
        end
      end
      ST_ADDR: begin
        if (w_field_done) w_next = r_is_write ? ST_DATA : ST_MEM;
      end
      ST_DATA: begin
        if (w_field_done) w_next = ST_MEM;
      end
      ST_MEM: begin
        if (mem_ready) begin
          w_next = ST_RESP;
          w_load = 1'b1;
          if (r_is_write) begin
            w_load_data = {24'h0, RSP_OK};
            w_load_cnt  = 3'd1;
          end else begin
            w_load_data = mem_rdata;
            w_load_cnt  = 3'd4;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_next      = ST_RESP;
          w_load      = 1'b1;
          w_load_data = {24'h0, RSP_ERR};
          w_load_cnt  = 3'd1;
        end
      end
      ST_RESP: begin
        if (w_tx_valid && tx_ready && w_tx_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_is_write  <= 1'b0;
      r_cnt       <= 2'd0;
      r_tmo       <= '0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_wstrb     <= 4'h0;
      r_mem_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (rx_valid) begin
            r_is_write <= (rx_data == CMD_WRITE);
            r_cnt      <= 2'd0;
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            // Word addressing: the received low two address bits are dropped.
            r_addr <= put_byte(r_addr, r_cnt,
                               (r_cnt == 2'd0) ? {rx_data[7:2], 2'b00} : rx_data);
            r_cnt  <= r_cnt + 2'd1;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            r_wdata <= put_byte(r_wdata, r_cnt, rx_data);
            r_cnt   <= r_cnt + 2'd1;
          end
        end
        ST_MEM: begin
          r_tmo <= r_tmo + TW'(1);
          if (w_next == ST_RESP) begin
            r_mem_valid <= 1'b0;
            r_wstrb     <= 4'h0;
          end
        end
        default: ;
      endcase
      if ((r_state != ST_MEM) && (w_next == ST_MEM)) begin
        r_mem_valid <= 1'b1;
        r_wstrb     <= r_is_write ? 4'hF : 4'h0;
        r_tmo       <= '0;
      end
    end
  end

  uart_mem_resp_shift u_resp (
    .sys_clk     (sys_clk),
    .sys_resetn  (sys_resetn),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .i_load_cnt  (w_load_cnt),
    .i_tx_ready  (tx_ready),
    .o_tx_data   (w_tx_data),
    .o_tx_valid  (w_tx_valid),
    .o_last      (w_tx_last)
  );

  assign tx_data   = w_tx_data;
  assign tx_valid  = w_tx_valid;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_mem_master.sv
// Directed bench for uart_mem_master: a command-level model predicts bus
// transactions and reply bytes; a per-cycle monitor checks the DUT against it.
module tb_uart_mem_master;

  localparam int TMO = 8;

  logic        sys_clk = 1'b0;
  logic        sys_resetn = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  uart_mem_master #(.TIMEOUT(TMO)) dut (
    .sys_clk    (sys_clk),
    .sys_resetn (sys_resetn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk_wdata;
    int          dur;
  } txn_t;

  txn_t        exp_txn[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] mem_m [logic [31:0]];
  int          checks = 0;
  int          failures = 0;
  logic        tx_hold = 1'b0;
  logic        no_ack = 1'b0;
  int          ack_delay = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Responder: acks after ack_delay+1 cycles of mem_valid; memory lives in mem_m.
  int rcnt = 0;
  always @(negedge sys_clk) begin
    if (!sys_resetn || !mem_valid) begin
      rcnt = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'hDEADBEEF;
    end else begin
      rcnt++;
      if (!no_ack && rcnt == ack_delay + 1) begin
        mem_ready = 1'b1;
        mem_rdata = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'h0;
        if (mem_wstrb == 4'hF) mem_m[mem_addr] = mem_wdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEADBEEF;
      end
    end
  end

  always @(negedge sys_clk) tx_ready = !tx_hold;

  // Monitor: sampled 1ns after the falling edge, inputs and outputs both settled.
  logic        c_active = 1'b0;
  int          c_len = 0;
  txn_t        c_cur;
  logic [31:0] c_wd = 32'h0;
  logic        c_ptv = 1'b0, c_prdy = 1'b0, c_phs = 1'b0;
  logic [7:0]  c_ptd = 8'h00;

  always begin
    @(negedge sys_clk);
    #1;
    if (!sys_resetn) begin
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_tx_valid",  32'(tx_valid),  32'd0);
      chk("rst_tx_data",   32'(tx_data),   32'd0);
      chk("rst_mem_addr",  mem_addr,       32'd0);
      chk("rst_mem_wdata", mem_wdata,      32'd0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      c_active = 1'b0;
      c_ptv = 1'b0; c_prdy = 1'b0; c_phs = 1'b0;
    end else begin
      if (mem_valid) begin
        chk("busy_in_mem", 32'(busy), 32'd1);
        if (!c_active) begin
          c_active = 1'b1;
          c_len = 1;
          c_wd = mem_wdata;
          if (exp_txn.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_mem_valid actual addr=%h required=no transaction", mem_addr);
            c_cur.addr = mem_addr; c_cur.wstrb = mem_wstrb; c_cur.dur = -1;
          end else begin
            c_cur = exp_txn.pop_front();
            chk("txn_addr",  mem_addr,       c_cur.addr);
            chk("txn_wstrb", 32'(mem_wstrb), 32'(c_cur.wstrb));
            if (c_cur.chk_wdata) chk("txn_wdata", mem_wdata, c_cur.wdata);
          end
        end else begin
          c_len++;
          chk("addr_stable",  mem_addr,       c_cur.addr);
          chk("wstrb_stable", 32'(mem_wstrb), 32'(c_cur.wstrb));
          chk("wdata_stable", mem_wdata,      c_wd);
        end
      end else if (c_active) begin
        c_active = 1'b0;
        if (c_cur.dur >= 0) chk("mem_valid_len", 32'(c_len), 32'(c_cur.dur));
      end
      if (c_ptv && !c_prdy) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_data",  32'(tx_data),  32'(c_ptd));
      end
      if (c_phs) chk("tx_gap", 32'(tx_valid), 32'd0);
      if (tx_valid) chk("busy_in_tx", 32'(busy), 32'd1);
      c_phs = tx_valid && tx_ready;
      if (c_phs) begin
        if (exp_tx.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_tx_byte actual=%h required=none", tx_data);
        end else begin
          chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
      end
      c_ptv = tx_valid; c_prdy = tx_ready; c_ptd = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    rx_data = b;
    rx_valid = 1'b1;
  endtask

  // Model: derives the expected bus transaction and reply bytes from the command.
  task automatic send_cmd(input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] d, input int gap, input logic killed);
    txn_t        t;
    logic [31:0] rd;
    logic        is_rw;
    is_rw = (op == 8'h52) || (op == 8'h57);
    if (is_rw) begin
      t.addr = {a[31:2], 2'b00};
      t.wdata = d;
      t.wstrb = (op == 8'h57) ? 4'hF : 4'h0;
      t.chk_wdata = (op == 8'h57);
      t.dur = killed ? -1 : (no_ack ? TMO : ack_delay + 1);
      exp_txn.push_back(t);
      if (!killed) begin
        if (no_ack) exp_tx.push_back(8'h45);
        else if (op == 8'h57) exp_tx.push_back(8'h4B);
        else begin
          rd = mem_m.exists(t.addr) ? mem_m[t.addr] : 32'h0;
          for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
        end
      end
    end else begin
      exp_tx.push_back(8'h3F);
    end
    send_byte(op);
    if (is_rw) begin
      for (int i = 0; i < 4; i++) begin
        for (int g = 0; g < gap; g++) begin @(negedge sys_clk); rx_valid = 1'b0; end
        send_byte(a[8*i +: 8]);
      end
      if (op == 8'h57)
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    end
    @(negedge sys_clk);
    rx_valid = 1'b0;
    #1;
    if (is_rw) chk("mem_valid_rise", 32'(mem_valid), 32'd1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge sys_clk);
      #1;
      if (!busy && !tx_valid && exp_tx.size() == 0) done = 1'b1;
    end
    chk("idle_reached", 32'(done), 32'd1);
  endtask

  initial begin
    mem_m[32'h4] = 32'h12345678;
    #2 sys_resetn = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1 sys_resetn = 1'b1;

    // Write, ack one cycle late
    ack_delay = 1;
    send_cmd(8'h57, 32'h00008000, 32'h000000A5, 0, 1'b0);
    chk("w_addr_lit",  mem_addr,       32'h00008000);
    chk("w_wdata_lit", mem_wdata,      32'h000000A5);
    chk("w_wstrb_lit", 32'(mem_wstrb), 32'hF);
    wait_idle();

    // Read with tx_ready held low, latency and stability
    tx_hold = 1'b1;
    send_cmd(8'h52, 32'h00000004, 32'h0, 1, 1'b0);
    chk("r_addr_lit",  mem_addr,       32'h00000004);
    chk("r_wstrb_lit", 32'(mem_wstrb), 32'h0);
    @(negedge sys_clk); #1;
    chk("r_lat2_txv", 32'(tx_valid), 32'd0);
    @(negedge sys_clk); #1;
    chk("r_lat3_txv", 32'(tx_valid), 32'd1);
    chk("r_first_lit", 32'(tx_data), 32'h78);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk); #1;
      chk("r_held_lit", 32'(tx_data), 32'h78);
    end
    tx_hold = 1'b0;
    wait_idle();

    // Unaligned address and unknown opcode
    send_cmd(8'h52, 32'h00000007, 32'h0, 0, 1'b0);
    chk("unal_addr_lit", mem_addr, 32'h00000004);
    wait_idle();
    send_cmd(8'h41, 32'h0, 32'h0, 0, 1'b0);
    chk("bad_txv",  32'(tx_valid), 32'd1);
    chk("bad_lit",  32'(tx_data),  32'h3F);
    wait_idle();

    // Same-cycle ack, write then read back
    ack_delay = 0;
    send_cmd(8'h57, 32'h0000000C, 32'hCAFEF00D, 0, 1'b0);
    wait_idle();
    send_cmd(8'h52, 32'h0000000C, 32'h0, 2, 1'b0);
    wait_idle();
    ack_delay = 1;
    send_cmd(8'h52, 32'h00008000, 32'h0, 0, 1'b0);
    wait_idle();

    // Timeouts
    no_ack = 1'b1;
    send_cmd(8'h57, 32'h00000020, 32'h00000055, 0, 1'b0);
    wait_idle();
    chk("tmo_no_write", 32'(mem_m.exists(32'h20)), 32'd0);
    send_cmd(8'h52, 32'h00000024, 32'h0, 0, 1'b0);
    wait_idle();

    // Asynchronous reset during MEM
    send_cmd(8'h52, 32'h00000010, 32'h0, 0, 1'b1);
    @(posedge sys_clk);
    #2 sys_resetn = 1'b0;
    #1;
    chk("async_mem_valid", 32'(mem_valid), 32'd0);
    chk("async_busy",      32'(busy),      32'd0);
    no_ack = 1'b0;
    repeat (2) @(negedge sys_clk);
    #1 sys_resetn = 1'b1;
    send_cmd(8'h52, 32'h00000004, 32'h0, 0, 1'b0);
    wait_idle();

    // Command byte during RESP is dropped
    tx_hold = 1'b1;
    send_cmd(8'h52, 32'h00000004, 32'h0, 0, 1'b0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge sys_clk); #1;
        if (tx_valid) seen = 1'b1;
      end
      chk("drop_resp_seen", 32'(seen), 32'd1);
    end
    send_byte(8'h52);
    @(negedge sys_clk);
    rx_valid = 1'b0;
    #1 tx_hold = 1'b0;
    wait_idle();
    repeat (10) @(negedge sys_clk);
    #1;
    chk("drop_busy", 32'(busy), 32'd0);

    chk("exp_tx_empty",  32'(exp_tx.size()),  32'd0);
    chk("exp_txn_empty", 32'(exp_txn.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_mem_master.md
# uart_mem_master

Bus initiator on the picorv32 native memory interface (mem_valid/mem_ready handshake) driven by a byte stream from the UART. It lets a host PC read and write any word-mapped location (RAM, LED, 7-seg, UART registers) over the serial link, for bootloading and debug. It sits between the UART byte interface and the system address decoder, in parallel with or instead of the CPU.

## Interface

Parameters:
- TIMEOUT, 1024, cycles to wait for mem_ready before aborting a transaction (minimum 2).

Ports (one clock; reset is asynchronous and active-low):
- sys_clk  in  1  system clock, all logic on rising edge
- sys_resetn  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle pulse, rx_data valid
- tx_data  out  8  response byte
- tx_valid  out  1  response byte pending
- tx_ready  in  1  UART accepts tx_data this cycle
- mem_valid  out  1  transaction request
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'b1111 on write, 4'b0000 on read
- mem_ready  in  1  responder acknowledge, data valid on reads
- mem_rdata  in  32  read data
- busy  out  1  high whenever the FSM is not in IDLE

## Operation

- Command framing, all multi-byte fields LSB first:
  - 0x57 'W', then addr[4 bytes], then data[4 bytes]: write the word, reply 0x4B 'K'.
  - 0x52 'R', then addr[4 bytes]: read the word, reply 4 data bytes, LSB first.
  - Any other first byte: reply 0x3F '?', return to IDLE.
- States: IDLE, ADDR (byte count 0..3), DATA (byte count 0..3, write only), MEM, RESP.
  - IDLE -> ADDR on 'R' or 'W'; IDLE -> RESP on an unknown byte.
  - ADDR -> DATA (write) or MEM (read) on the 4th address byte.
  - DATA -> MEM on the 4th data byte.
  - MEM -> RESP when mem_ready is sampled high or on timeout.
  - RESP -> IDLE when the last response byte is accepted.
- Address bits [1:0] are forced to 0 at capture; the received low bits are discarded.
- Read data is latched from mem_rdata in the cycle mem_ready is high.
- Timeout: a counter is cleared on entry to MEM and increments each cycle there. When it reaches TIMEOUT-1 with no mem_ready, mem_valid is dropped and the reply is 0x45 'E' (one byte, for both R and W).
- rx_valid pulses while in MEM or RESP are dropped; there is no buffering.
- Reset values: tx_data=0, tx_valid=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0; FSM in IDLE; all counters 0.
- Reset mid-transaction: every output returns to its reset value immediately (asynchronous), and any partial command is lost.

## Timing

- All outputs are registered.
- mem_valid rises in the cycle after the final command byte is captured.
- mem_addr, mem_wdata and mem_wstrb are stable from that cycle until mem_valid falls.
- mem_valid is held until the first rising edge where mem_ready=1, and is low on the next cycle. Same-cycle ready (the responder acks in the first mem_valid cycle) is legal.
- Compatible with the system's one-cycle-delayed ack: 'R' latency from the last address byte to the first tx_valid is 3 cycles.
- tx_valid rises in the cycle after MEM exits and stays high with tx_data stable until tx_ready=1. The next byte is presented on the following cycle, so there is at most one byte per 2 cycles.
- If rx_valid and tx_ready fall in the same cycle in RESP, only the tx handshake acts.

## Structure

- Package uart_mem_master_pkg holds:
  - command constants CMD_READ=8'h52, CMD_WRITE=8'h57;
  - reply constants RSP_OK=8'h4B, RSP_ERR=8'h45, RSP_BAD=8'h3F;
  - the state enum.
- One sub-module, uart_mem_resp_shift, is natural: a 32-bit load and byte-shift register with a byte count and the tx_valid/tx_ready handshake. It is loaded with 1 or 4 bytes.
- All other logic (byte assembly, FSM, timeout counter) lives in the top module.

## Test plan

- Write: bytes 57 00 80 00 00 A5 00 00 00 -> one mem_valid pulse with addr 0x00008000, wdata 0x000000A5, wstrb 1111. Ack 1 cycle later -> tx byte 0x4B.
- Read: bytes 52 04 00 00 00 with the responder returning 0x12345678 -> mem_addr 0x00000004, wstrb 0000, tx bytes 78 56 34 12 in order. Hold tx_ready low for 5 cycles and check tx_data stays stable.
- Unaligned/unknown: 52 07 00 00 00 -> mem_addr 0x00000004. A lone byte 0x41 -> tx byte 0x3F, and no mem_valid.
- Timeout: TIMEOUT=8 with mem_ready tied low -> mem_valid high for exactly 8 cycles, then tx byte 0x45, then IDLE.
- Reset during MEM (mem_valid high): assert sys_resetn low mid-cycle -> mem_valid and busy fall without a clock. After release, a fresh 'R' command completes normally.
- Drop: send 0x52 during the RESP of a prior read -> it is ignored; no new transaction starts after RESP completes.
